pattern_matcher: RTL and testbench

//  Avalon-ST pass-through stage that sits downstream of the control register. It scans each packet
//  for the key pattern (PAT_BYTES symbols), including occurrences that span beat boundaries.
//  On the eop beat it flags the packet on src_channel_o when a match was found. Data is forwarded unchanged.

---
 rtl/pattern_matcher_pkg.sv | 38 +++
 rtl/pattern_matcher_if.sv | 34 +++
 rtl/pattern_matcher_window.sv | 71 +++++++
 rtl/pattern_matcher.sv | 98 +++++++++
 tb/tb_pattern_matcher.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_matcher_pkg.sv
// Shared constants, symbol types and unpack helpers for the pattern matcher.
// Symbol 0 is always the most significant byte of a packed word (first on the wire).
package pattern_matcher_pkg;

  localparam int DATA_WIDTH    = 64;
  localparam int BIT_PER_SYMB  = 8;
  localparam int PAT_WIDTH     = 3;
  localparam int REG_WIDTH     = 32;
  localparam int PAT_SIZE      = PAT_WIDTH * REG_WIDTH;
  localparam int SYMB_PER_BEAT = DATA_WIDTH / BIT_PER_SYMB;
  localparam int PAT_BYTES     = PAT_SIZE / BIT_PER_SYMB;
  localparam int HIST_BYTES    = PAT_BYTES - 1;
  localparam int WIN_BYTES     = HIST_BYTES + SYMB_PER_BEAT;
  localparam int EMPTY_WIDTH   = $clog2(SYMB_PER_BEAT);
  localparam int CNT_WIDTH     = $clog2(PAT_BYTES);

  typedef logic [BIT_PER_SYMB-1:0] symb_t;
  typedef symb_t [SYMB_PER_BEAT-1:0] beat_symb_t;
  typedef symb_t [PAT_BYTES-1:0]     key_symb_t;
  typedef symb_t [HIST_BYTES-1:0]    hist_symb_t;

  function automatic beat_symb_t unpack_beat(input logic [DATA_WIDTH-1:0] d);
    beat_symb_t r;
    for (int i = 0; i < SYMB_PER_BEAT; i++) begin
      r[i] = d[DATA_WIDTH-1-i*BIT_PER_SYMB -: BIT_PER_SYMB];
    end
    return r;
  endfunction

  function automatic key_symb_t unpack_key(input logic [PAT_SIZE-1:0] k);
    key_symb_t r;
    for (int i = 0; i < PAT_BYTES; i++) begin
      r[i] = k[PAT_SIZE-1-i*BIT_PER_SYMB -: BIT_PER_SYMB];
    end
    return r;
  endfunction

endpackage

// File: rtl/pattern_matcher_if.sv
// Avalon-ST sink and source of the pattern matcher, named from the matcher's point of view.
// A beat transfers on a rising edge where valid and ready are both high (readyLatency 0);
// the sender holds every qualifier stable until that edge, and ready may not depend on a later valid.
interface pattern_matcher_if;
  import pattern_matcher_pkg::*;

  logic [DATA_WIDTH-1:0]  snk_data_i;
  logic                   snk_valid_i;
  logic                   snk_sop_i;
  logic                   snk_eop_i;
  logic [EMPTY_WIDTH-1:0] snk_empty_i;
  logic                   snk_ready_o;

  logic [DATA_WIDTH-1:0]  src_data_o;
  logic                   src_valid_o;
  logic                   src_sop_o;
  logic                   src_eop_o;
  logic [EMPTY_WIDTH-1:0] src_empty_o;
  logic                   src_channel_o;
  logic                   src_ready_i;

  modport master (
    output snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_empty_i, src_ready_i,
    input  snk_ready_o, src_data_o, src_valid_o, src_sop_o, src_eop_o, src_empty_o,
           src_channel_o
  );

  modport slave (
    input  snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_empty_i, src_ready_i,
    output snk_ready_o, src_data_o, src_valid_o, src_sop_o, src_eop_o, src_empty_o,
           src_channel_o
  );

endinterface

// File: rtl/pattern_matcher_window.sv
// Sliding symbol window: keeps the last PAT_BYTES-1 symbols of the packet plus the latched key
// and reports, combinationally, whether any key occurrence ends inside the presented beat.
module pattern_window
  import pattern_matcher_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [0:PAT_SIZE-1]    pattern_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [EMPTY_WIDTH-1:0] empty_i,
  input  logic                   sop_i,
  input  logic                   eop_i,
  input  logic                   accept_i,
  output logic                   hit_o
);

  hist_symb_t              hist_q, hist_d;
  key_symb_t               key_q, key_d, key_eff;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  symb_t [WIN_BYTES-1:0]   win;
  beat_symb_t              beat;
  int                      cnt_eff;
  int                      n_valid;
  logic                    match;

  // win[0] is the oldest history symbol, win[WIN_BYTES-1] the last lane of this beat.
  always_comb begin
    beat    = unpack_beat(data_i);
    key_eff = sop_i ? unpack_key(pattern_i) : key_q;
    cnt_eff = sop_i ? 0 : int'(cnt_q);
    n_valid = eop_i ? SYMB_PER_BEAT - int'(empty_i) : SYMB_PER_BEAT;
    win     = '0;
    for (int i = 0; i < HIST_BYTES; i++) win[i] = hist_q[i];
    for (int i = 0; i < SYMB_PER_BEAT; i++) win[HIST_BYTES+i] = beat[i];
    hit_o = 1'b0;
    match = 1'b0;
    for (int e = 0; e < SYMB_PER_BEAT; e++) begin
      // The window ending at lane e starts at win[e]; it needs e+cnt_eff >= HIST_BYTES real symbols.
      match = (e < n_valid) && (e + cnt_eff >= HIST_BYTES);
      for (int k = 0; k < PAT_BYTES; k++) begin
        if (win[e+k] != key_eff[k]) match = 1'b0;
      end
      hit_o = hit_o | match;
    end
  end

  always_comb begin
    hist_d = hist_q;
    key_d  = key_q;
    cnt_d  = cnt_q;
    if (accept_i) begin
      for (int i = 0; i < HIST_BYTES; i++) hist_d[i] = win[i+SYMB_PER_BEAT];
      key_d = key_eff;
      cnt_d = (cnt_eff + n_valid > HIST_BYTES) ? CNT_WIDTH'(HIST_BYTES)
                                               : CNT_WIDTH'(cnt_eff + n_valid);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      hist_q <= '0;
      key_q  <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      key_q  <= key_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_matcher.sv
// Avalon-ST pass-through with one output register; flags on the eop beat whether the packet
// contained the key latched at its sop.
module pattern_matcher
  import pattern_matcher_pkg::*;
(
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [0:PAT_SIZE-1] pattern_i,
  input  logic                wrken_i,
  pattern_matcher_if.slave    bus
);

  logic                   src_valid_q, src_valid_d;
  logic                   src_sop_q, src_sop_d;
  logic                   src_eop_q, src_eop_d;
  logic                   src_channel_q, src_channel_d;
  logic [DATA_WIDTH-1:0]  src_data_q, src_data_d;
  logic [EMPTY_WIDTH-1:0] src_empty_q, src_empty_d;
  logic                   en_q, en_d;
  logic                   acc_q, acc_d;
  logic                   snk_ready;
  logic                   accept;
  logic                   hit;
  logic                   en_eff;
  logic                   acc_eff;

  assign snk_ready = bus.src_ready_i | ~src_valid_q;
  assign accept    = bus.snk_valid_i & snk_ready;
  assign en_eff    = bus.snk_sop_i ? wrken_i : en_q;
  assign acc_eff   = bus.snk_sop_i ? 1'b0 : acc_q;

  pattern_window u_window (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .pattern_i (pattern_i),
    .data_i    (bus.snk_data_i),
    .empty_i   (bus.snk_empty_i),
    .sop_i     (bus.snk_sop_i),
    .eop_i     (bus.snk_eop_i),
    .accept_i  (accept),
    .hit_o     (hit)
  );

  always_comb begin
    src_valid_d   = src_valid_q;
    src_sop_d     = src_sop_q;
    src_eop_d     = src_eop_q;
    src_channel_d = src_channel_q;
    src_data_d    = src_data_q;
    src_empty_d   = src_empty_q;
    en_d          = en_q;
    acc_d         = acc_q;
    if (accept) begin
      src_valid_d   = 1'b1;
      src_sop_d     = bus.snk_sop_i;
      src_eop_d     = bus.snk_eop_i;
      src_data_d    = bus.snk_data_i;
      src_empty_d   = bus.snk_empty_i;
      src_channel_d = bus.snk_eop_i & en_eff & (acc_eff | hit);
      en_d          = en_eff;
      acc_d         = acc_eff | hit;
    end else if (bus.src_ready_i) begin
      src_valid_d   = 1'b0;
      src_channel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      src_valid_q   <= 1'b0;
      src_sop_q     <= 1'b0;
      src_eop_q     <= 1'b0;
      src_channel_q <= 1'b0;
      src_data_q    <= '0;
      src_empty_q   <= '0;
      en_q          <= 1'b0;
      acc_q         <= 1'b0;
    end else begin
      src_valid_q   <= src_valid_d;
      src_sop_q     <= src_sop_d;
      src_eop_q     <= src_eop_d;
      src_channel_q <= src_channel_d;
      src_data_q    <= src_data_d;
      src_empty_q   <= src_empty_d;
      en_q          <= en_d;
      acc_q         <= acc_d;
    end
  end

  assign bus.snk_ready_o   = snk_ready;
  assign bus.src_valid_o   = src_valid_q;
  assign bus.src_sop_o     = src_sop_q;
  assign bus.src_eop_o     = src_eop_q;
  assign bus.src_channel_o = src_channel_q;
  assign bus.src_data_o    = src_data_q;
  assign bus.src_empty_o   = src_empty_q;

endmodule

// File: tb/tb_pattern_matcher.sv
// Directed and randomised-backpressure bench for pattern_matcher with an expected-beat scoreboard.
module tb_pattern_matcher;
  import pattern_matcher_pkg::*;

  localparam int W = 3 + EMPTY_WIDTH + DATA_WIDTH;

  logic                clk = 1'b0;
  logic                srst = 1'b1;
  logic [0:PAT_SIZE-1] pattern;
  logic                wrken;
  bit                  rand_ready = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]  pkt_buf[256];
  logic [7:0]  key_b[PAT_BYTES];

  pattern_matcher_if bus();

  pattern_matcher dut (
    .clk_i     (clk),
    .srst_i    (srst),
    .pattern_i (pattern),
    .wrken_i   (wrken),
    .bus       (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- source backpressure ----------------
  initial begin
    bus.src_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.src_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] prev_beat;
  bit           stalled = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] cur;
    cur = {bus.src_channel_o, bus.src_sop_o, bus.src_eop_o, bus.src_empty_o, bus.src_data_o};
    if (srst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {bus.src_valid_o, cur}, {1'b1, prev_beat});
      if (bus.src_valid_o && bus.src_ready_i) begin
        check("sb_has_exp", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("beat", cur, exp_q.pop_front());
      end
      stalled   = bus.src_valid_o && !bus.src_ready_i;
      prev_beat = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DATA_WIDTH-1:0] d, input logic s, input logic e,
                           input logic [EMPTY_WIDTH-1:0] emp);
    bit acc = 1'b0;
    int t   = 0;
    bus.snk_data_i  = d;
    bus.snk_sop_i   = s;
    bus.snk_eop_i   = e;
    bus.snk_empty_i = emp;
    bus.snk_valid_i = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.snk_ready_o;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 500);
    bus.snk_valid_i = 1'b0;
    if (!acc) check("accept_timeout", acc, 1'b1);
  endtask

  // mid_mode 1: invert pattern after sop; 2: raise wrken after sop.
  task automatic send_pkt(input int nbeats, input int emp, input bit exp_ch, input int mid_mode);
    for (int b = 0; b < nbeats; b++) begin
      logic [DATA_WIDTH-1:0]  d;
      logic                   s, e;
      logic [EMPTY_WIDTH-1:0] em;
      for (int j = 0; j < SYMB_PER_BEAT; j++) d[DATA_WIDTH-1-8*j -: 8] = pkt_buf[b*8+j];
      s  = (b == 0);
      e  = (b == nbeats - 1);
      em = e ? EMPTY_WIDTH'(emp) : '0;
      exp_q.push_back({e & exp_ch, s, e, em, d});
      send_beat(d, s, e, em);
      if (b == 0 && mid_mode == 1) pattern = ~pattern;
      if (b == 0 && mid_mode == 2) wrken = 1'b1;
      if (rand_ready) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill_buf();
    for (int i = 0; i < 256; i++) pkt_buf[i] = 8'h80 | 8'(i % 128);
  endtask

  task automatic put_key(input int off, input int from, input int to);
    for (int k = from; k <= to; k++) pkt_buf[off + k - from] = key_b[k];
  endtask

  task automatic load_pattern();
    for (int k = 0; k < PAT_BYTES; k++) pattern[k*8 +: 8] = key_b[k];
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(posedge clk); #1; t++; end
    check(tag, exp_q.size(), 0);
  endtask

  function automatic bit model_match(input int len, input bit en);
    bit found = 1'b0;
    for (int s = 0; s + PAT_BYTES <= len; s++) begin
      bit eq = 1'b1;
      for (int k = 0; k < PAT_BYTES; k++) if (pkt_buf[s+k] != key_b[k]) eq = 1'b0;
      if (eq) found = 1'b1;
    end
    return en & found;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.snk_valid_i = 1'b0;
    bus.snk_data_i  = '0;
    bus.snk_sop_i   = 1'b0;
    bus.snk_eop_i   = 1'b0;
    bus.snk_empty_i = '0;
    wrken = 1'b1;
    for (int k = 0; k < PAT_BYTES; k++) key_b[k] = 8'(k + 1);
    load_pattern();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.src_valid_o, 1'b0);
    check("rst_channel", bus.src_channel_o, 1'b0);
    check("rst_fields", {bus.src_sop_o, bus.src_eop_o, bus.src_empty_o, bus.src_data_o}, '0);
    @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.snk_ready_o, 1'b1);
    idle(1);

    // key in the middle beat; eop beat appears one clock after its accept
    fill_buf(); put_key(8, 0, 11);
    send_pkt(3, 0, 1'b1, 0);
    @(negedge clk);
    check("t1_latency", {bus.src_valid_o, bus.src_eop_o}, 2'b11);
    idle(2);

    // key split 5 + 7 across beats 0/1
    fill_buf(); put_key(3, 0, 11);
    send_pkt(3, 0, 1'b1, 0);
    // last two key bytes masked by empty=2, then unmasked
    fill_buf(); put_key(4, 0, 11);
    send_pkt(2, 2, 1'b0, 0);
    send_pkt(2, 0, 1'b1, 0);
    // exact 12-byte packet equal to the key
    fill_buf(); put_key(0, 0, 11);
    send_pkt(2, 4, 1'b1, 0);
    // single-beat packet holding a key prefix
    fill_buf(); put_key(0, 0, 7);
    send_pkt(1, 0, 1'b0, 0);
    // key spans packet boundary
    fill_buf(); put_key(11, 0, 4);
    send_pkt(2, 0, 1'b0, 0);
    fill_buf(); put_key(0, 5, 11);
    send_pkt(2, 0, 1'b0, 0);
    // match disabled at sop, and enabled only mid-packet
    wrken = 1'b0;
    fill_buf(); put_key(2, 0, 11);
    send_pkt(3, 0, 1'b0, 0);
    fill_buf(); put_key(8, 0, 11);
    send_pkt(3, 0, 1'b0, 2);
    // pattern changes mid-packet are ignored
    fill_buf(); put_key(8, 0, 11);
    send_pkt(3, 0, 1'b1, 1);
    load_pattern();
    // repeated occurrences
    fill_buf(); put_key(0, 0, 11); put_key(14, 0, 11);
    send_pkt(4, 0, 1'b1, 0);
    drain("drain_directed");

    // random packets under random backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      int len, nb;
      bit en;
      len = $urandom_range(1, 40);
      nb  = (len + 7) / 8;
      for (int i = 0; i < nb * 8; i++) pkt_buf[i] = 8'($urandom_range(0, 255));
      if (len >= PAT_BYTES && $urandom_range(0, 1) == 1) put_key($urandom_range(0, len - PAT_BYTES), 0, 11);
      en    = ($urandom_range(0, 4) != 0);
      wrken = en;
      send_pkt(nb, nb * 8 - len, model_match(len, en), 0);
    end
    rand_ready = 1'b0;
    wrken = 1'b1;
    drain("drain_random");

    // reset mid-packet
    fill_buf(); put_key(8, 0, 7);
    for (int b = 0; b < 2; b++) begin
      logic [DATA_WIDTH-1:0] d;
      for (int j = 0; j < SYMB_PER_BEAT; j++) d[DATA_WIDTH-1-8*j -: 8] = pkt_buf[b*8+j];
      exp_q.push_back({1'b0, b == 0, 1'b0, {EMPTY_WIDTH{1'b0}}, d});
      send_beat(d, b == 0, 1'b0, '0);
    end
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_valid", bus.src_valid_o, 1'b0);
    @(posedge clk);
    #1 srst = 1'b0;
    exp_q.delete();
    // remainder of the key after reset must not complete the old prefix
    fill_buf(); put_key(0, 8, 11);
    send_pkt(2, 0, 1'b0, 0);
    fill_buf(); put_key(5, 0, 11);
    send_pkt(3, 0, 1'b1, 0);
    fill_buf();
    send_pkt(3, 0, 1'b0, 0);
    drain("drain_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
